// File: rtl/register_mode_pkg.sv
// rtl/register_mode_pkg.sv - shared mode constants, config opcodes and sequencer states
package register_mode_pkg;

   localparam logic [1:0] MODE_CONST  = 2'h0;
   localparam logic [1:0] MODE_VALUE  = 2'h1;
   localparam logic [1:0] MODE_BYPASS = 2'h2;
   localparam logic [1:0] MODE_DELAY  = 2'h3;

   typedef enum logic [1:0] {
      OP_WR_MODE  = 2'd0,
      OP_WR_CONST = 2'd1,
      OP_WR_REG   = 2'd2,
      OP_RD_REG   = 2'd3
   } cfg_op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GATE    = 3'd1,
      ST_WRITE   = 3'd2,
      ST_RELEASE = 3'd3,
      ST_SAMPLE  = 3'd4
   } state_e;

endpackage

// File: rtl/register_mode_cfg_slot.sv
// rtl/register_mode_cfg_slot.sv - mode/const_ storage for one RegisterMode slot
module register_mode_cfg_slot
   import register_mode_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             ASYNCRESET,
   input  logic             mode_we,
   input  logic             const_we,
   input  logic [WIDTH-1:0] data,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] const_
);

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         mode   <= MODE_CONST;
         const_ <= '0;
      end else begin
         if (mode_we)  mode   <= data[1:0];
         if (const_we) const_ <= data;
      end
   end

endmodule

// File: rtl/register_mode_cfg_ctrl.sv
// rtl/register_mode_cfg_ctrl.sv - config sequencer for NUM_REGS RegisterMode slots
// Build option CFG_READBACK_EN enables RD_REG readback through slot_value.
module register_mode_cfg_ctrl
   import register_mode_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int WIDTH    = 4,
   parameter int ADDR_W   = 2
) (
   input  logic                      CLK,
   input  logic                      ASYNCRESET,
   input  logic                      run,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [1:0]                cfg_op,
   input  logic [ADDR_W-1:0]         cfg_addr,
   input  logic [WIDTH-1:0]          cfg_data,
   output logic                      cfg_err,
   output logic [2*NUM_REGS-1:0]     mode,
   output logic [WIDTH*NUM_REGS-1:0] const_,
   output logic [NUM_REGS-1:0]       clk_en,
   output logic [NUM_REGS-1:0]       config_we,
   output logic [WIDTH-1:0]          config_data,
   input  logic [WIDTH*NUM_REGS-1:0] slot_value,
   output logic                      rd_valid,
   output logic [WIDTH-1:0]          rd_data
);

   state_e                   state, state_nx;
   logic [ADDR_W-1:0]        addr_q, tgt_nx;
   logic [WIDTH-1:0]         data_q;
   logic                     accept, err_nx, busy_nx;
   logic [2**ADDR_W-1:0]     addr_ok;
   logic [NUM_REGS-1:0]      sel, mode_we, const_we, clk_en_nx, we_nx;
   cfg_op_e                  op;

   assign accept = cfg_valid & cfg_ready;
   assign op     = cfg_op_e'(cfg_op);

   always_comb begin
      addr_ok = '0;
      for (int k = 0; k < 2**ADDR_W; k++) addr_ok[k] = (k < NUM_REGS);
      sel = '0;
      for (int i = 0; i < NUM_REGS; i++) sel[i] = (cfg_addr == ADDR_W'(i));
   end

   always_comb begin
      state_nx = state;
      err_nx   = 1'b0;
      mode_we  = '0;
      const_we = '0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (!addr_ok[cfg_addr]) begin
                  err_nx = 1'b1;
               end else begin
                  case (op)
                     OP_WR_MODE:  mode_we  = sel;
                     OP_WR_CONST: const_we = sel;
                     OP_WR_REG:   state_nx = ST_GATE;
                     OP_RD_REG: begin
`ifdef CFG_READBACK_EN
                        state_nx = ST_SAMPLE;
`else
                        err_nx = 1'b1;
`endif
                     end
                     default:     err_nx = 1'b1;
                  endcase
               end
            end
         end
         ST_GATE:    state_nx = ST_WRITE;
         ST_WRITE:   state_nx = ST_RELEASE;
         ST_RELEASE: state_nx = ST_IDLE;
         ST_SAMPLE:  state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Gating and the write strobe are derived from the next state so they stay registered outputs.
   always_comb begin
      tgt_nx  = (state == ST_IDLE) ? cfg_addr : addr_q;
      busy_nx = (state_nx == ST_GATE) || (state_nx == ST_WRITE) || (state_nx == ST_RELEASE);
      clk_en_nx = '0;
      we_nx     = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         clk_en_nx[i] = run & ~(busy_nx & (tgt_nx == ADDR_W'(i)));
         we_nx[i]     = (state_nx == ST_WRITE) & (tgt_nx == ADDR_W'(i));
      end
   end

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         state       <= ST_IDLE;
         cfg_ready   <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         clk_en      <= '0;
         config_we   <= '0;
         config_data <= '0;
         cfg_err     <= 1'b0;
      end else begin
         state     <= state_nx;
         cfg_ready <= (state_nx == ST_IDLE);
         if (accept) begin
            addr_q <= cfg_addr;
            data_q <= cfg_data;
         end
         clk_en    <= clk_en_nx;
         config_we <= we_nx;
         cfg_err   <= err_nx;
         if (state_nx == ST_WRITE) config_data <= data_q;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
      register_mode_cfg_slot #(.WIDTH(WIDTH)) u_slot (
         .CLK        (CLK),
         .ASYNCRESET (ASYNCRESET),
         .mode_we    (mode_we[g]),
         .const_we   (const_we[g]),
         .data       (cfg_data),
         .mode       (mode[2*g +: 2]),
         .const_     (const_[WIDTH*g +: WIDTH])
      );
   end

`ifdef CFG_READBACK_EN
   logic [WIDTH-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (addr_q == ADDR_W'(i)) rd_mux = slot_value[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= (state == ST_SAMPLE);
         if (state == ST_SAMPLE) rd_data <= rd_mux;
      end
   end
`else
   logic unused_slot_value;
   assign unused_slot_value = ^slot_value;
   assign rd_valid = 1'b0;
   assign rd_data  = '0;
`endif

endmodule
